// File: rtl/adpcm_mul_arbiter_pkg.sv
// adpcm_mul_pkg: shared widths and round-robin pick for the ADPCM multiplier arbiter.
package adpcm_mul_pkg;
    localparam int A_W = 32;
    localparam int B_W = 15;
    localparam int P_W = A_W + B_W;
    localparam int MAX_REQ = 8;

    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
    } pick_t;

    // First asserted valid scanning upward from ptr+1, wrapping at n.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] v, input logic [2:0] ptr, input int n);
        pick_t r;
        logic [2:0] i;
        r = '0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            i = 3'((int'(ptr) + k) % n);
            if (k <= n && !r.hit && v[i]) begin
                r.hit = 1'b1;
                r.idx = i;
            end
        end
        return r;
    endfunction
endpackage

// File: rtl/adpcm_mul_arbiter_if.sv
// adpcm_mul_arbiter_if: requester operand bus and tagged product response bus.
interface adpcm_mul_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int A_W = adpcm_mul_pkg::A_W,
    parameter int B_W = adpcm_mul_pkg::B_W,
    parameter int P_W = A_W + B_W
);
    localparam int ID_W = $clog2(NUM_REQ);
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*A_W-1:0] req_a;
    logic [NUM_REQ*B_W-1:0] req_b;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic [P_W-1:0]         rsp_data;

    modport master (output req_valid, req_a, req_b, rsp_ready,
                    input  req_ready, rsp_valid, rsp_id, rsp_data);
    modport slave  (input  req_valid, req_a, req_b, rsp_ready,
                    output req_ready, rsp_valid, rsp_id, rsp_data);
endinterface

// File: rtl/adpcm_arb_mul_core.sv
// adpcm_arb_mul_core: one-register signed x {0,unsigned} multiplier with clock enable.
module adpcm_arb_mul_core #(
    parameter int A_W = adpcm_mul_pkg::A_W,
    parameter int B_W = adpcm_mul_pkg::B_W,
    parameter int P_W = A_W + B_W
) (
    input  logic           clk,
    input  logic           ce_i,
    input  logic [A_W-1:0] a_i,
    input  logic [B_W-1:0] b_i,
    output logic [P_W-1:0] p_o
);
    logic signed [P_W-1:0] a_x, b_x;
    logic        [P_W-1:0] p_q;

    // Both operands widened to the product width so the multiply is exact.
    assign a_x = {{(P_W-A_W){a_i[A_W-1]}}, a_i};
    assign b_x = {{(P_W-B_W){1'b0}}, b_i};

    always_ff @(posedge clk)
        if (ce_i) p_q <= a_x * b_x;

    assign p_o = p_q;
endmodule

// File: rtl/adpcm_mul_arbiter.sv
// adpcm_mul_arbiter: round-robin sharing of one pipelined multiplier among NUM_REQ requesters.
module adpcm_mul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int A_W = adpcm_mul_pkg::A_W,
    parameter int B_W = adpcm_mul_pkg::B_W,
    parameter int P_W = A_W + B_W
) (
    input  logic clk,
    input  logic reset_n,
    adpcm_mul_arbiter_if.slave bus,
    output logic busy
);
    import adpcm_mul_pkg::*;
    localparam int ID_W = $clog2(NUM_REQ);

    pick_t              pick;
    logic               advance, xfer;
    logic [NUM_REQ-1:0] ready;
    logic [ID_W-1:0]    grant, ptr_q, ptr_d, s1_id_q, s1_id_d, rsp_id_q, rsp_id_d;
    logic               s1_valid_q, s1_valid_d, rsp_valid_q, rsp_valid_d;
    logic [A_W-1:0]     a_sel;
    logic [B_W-1:0]     b_sel;
    logic [P_W-1:0]     prod, rsp_data_q, rsp_data_d;

    always_comb begin
        advance     = !rsp_valid_q || bus.rsp_ready;
        pick        = rr_pick(8'(bus.req_valid), 3'(ptr_q), NUM_REQ);
        grant       = ID_W'(pick.idx);
        xfer        = reset_n && advance && pick.hit;
        ready       = xfer ? NUM_REQ'(1) << grant : '0;
        a_sel       = bus.req_a[grant*A_W +: A_W];
        b_sel       = bus.req_b[grant*B_W +: B_W];
        ptr_d       = xfer ? grant : ptr_q;
        s1_valid_d  = advance ? xfer : s1_valid_q;
        s1_id_d     = xfer ? grant : s1_id_q;
        rsp_valid_d = advance ? s1_valid_q : rsp_valid_q;
        rsp_id_d    = (advance && s1_valid_q) ? s1_id_q : rsp_id_q;
        rsp_data_d  = (advance && s1_valid_q) ? prod : rsp_data_q;
    end

    // The whole pipeline moves together on advance, so a stall freezes every stage.
    adpcm_arb_mul_core #(.A_W(A_W), .B_W(B_W), .P_W(P_W)) u_mul (
        .clk  (clk),
        .ce_i (advance),
        .a_i  (a_sel),
        .b_i  (b_sel),
        .p_o  (prod)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q       <= ID_W'(NUM_REQ - 1);
            s1_valid_q  <= 1'b0;
            s1_id_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            s1_valid_q  <= s1_valid_d;
            s1_id_q     <= s1_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign bus.req_ready = ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign busy          = s1_valid_q || rsp_valid_q;
endmodule

// File: tb/tb_adpcm_mul_arbiter.sv
// tb_adpcm_mul_arbiter: directed and random checks of the arbiter against a slot-level reference model.
module tb_adpcm_mul_arbiter;
    localparam int N = 4, AW = 32, BW = 15, PW = 47;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic busy;
    int tests = 0, fails = 0, rsp_seen = 0, last_grant = -1;

    always #5 clk = ~clk;

    adpcm_mul_arbiter_if #(.NUM_REQ(N), .A_W(AW), .B_W(BW), .P_W(PW)) bus ();
    adpcm_mul_arbiter #(.NUM_REQ(N), .A_W(AW), .B_W(BW), .P_W(PW)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus), .busy(busy));

    typedef struct { bit v; int id; logic [PW-1:0] p; } slot_t;
    slot_t m_s1, m_out;
    int m_ptr;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] prod(input logic [AW-1:0] a, input logic [BW-1:0] b);
        longint r;
        r = longint'($signed(a)) * longint'(b);
        return r[PW-1:0];
    endfunction

    function automatic int pick(input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic mreset();
        m_s1.v = 0;
        m_out.v = 0;
        m_ptr = N - 1;
    endtask

    // One cycle: check outputs against the model, then advance model and clock together.
    task automatic step();
        int g;
        bit adv;
        logic [N-1:0] exp_rdy;
        #1;
        adv = !m_out.v || bus.rsp_ready;
        g = adv ? pick(bus.req_valid) : -1;
        exp_rdy = (g >= 0) ? N'(1) << g : '0;
        check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
        check("rsp_valid", 64'(bus.rsp_valid), 64'(m_out.v));
        if (m_out.v) begin
            check("rsp_id", 64'(bus.rsp_id), 64'(m_out.id));
            check("rsp_data", 64'(bus.rsp_data), 64'(m_out.p));
        end
        check("busy", 64'(busy), 64'(m_s1.v || m_out.v));
        if (bus.rsp_valid && bus.rsp_ready) rsp_seen++;
        last_grant = g;
        if (adv) begin
            m_out = m_s1;
            m_s1.v = (g >= 0);
            if (g >= 0) begin
                m_s1.id = g;
                m_s1.p = prod(bus.req_a[g*AW +: AW], bus.req_b[g*BW +: BW]);
                m_ptr = g;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic single(input logic [AW-1:0] a, input logic [BW-1:0] b, input logic [PW-1:0] exp, input string tag);
        bus.req_valid = 4'b0001;
        bus.req_a[AW-1:0] = a;
        bus.req_b[BW-1:0] = b;
        step();
        bus.req_valid = '0;
        bus.req_a = '0;
        check({tag, "_busy1"}, 64'(busy), 64'd1);
        check({tag, "_rv_early"}, 64'(bus.rsp_valid), 64'd0);
        step();
        check({tag, "_rv"}, 64'(bus.rsp_valid), 64'd1);
        check({tag, "_id"}, 64'(bus.rsp_id), 64'd0);
        check({tag, "_data"}, 64'(bus.rsp_data), 64'(exp));
        check({tag, "_busy2"}, 64'(busy), 64'd1);
        step();
        check({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [PW-1:0] hold_data;
        logic [63:0] hold_id;
        int prev, seen0;
        mreset();
        bus.req_valid = '1;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.rsp_ready = 1'b1;
        #1;
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
        check("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        bus.req_valid = '0;

        single(32'hFFFF_FFFD, 15'd5, 47'h7FFF_FFFF_FFF1, "neg3x5");
        single(32'h8000_0000, 15'h7FFF, 47'(-64'sd70366596694016), "min_x_max");
        single(32'h7FFF_FFFF, 15'd0, 47'd0, "max_x_0");

        // All four contending: ptr sits at 0, so service continues 1,2,3 then wraps.
        bus.req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            bus.req_a = {$urandom, $urandom, $urandom, $urandom};
            bus.req_b = 60'({$urandom, $urandom});
            step();
            check("rr_seq", 64'(last_grant), 64'((k + 1) % N));
        end
        bus.req_valid = '0;
        repeat (3) step();

        // Backpressure with the pipeline full.
        bus.req_valid = '1;
        repeat (3) step();
        bus.rsp_ready = 1'b0;
        hold_data = bus.rsp_data;
        hold_id = 64'(bus.rsp_id);
        repeat (4) begin
            bus.req_a = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        check("stall_data", 64'(bus.rsp_data), 64'(hold_data));
        check("stall_id", 64'(bus.rsp_id), hold_id);
        check("stall_valid", 64'(bus.rsp_valid), 64'd1);
        bus.rsp_ready = 1'b1;
        bus.req_valid = '0;
        seen0 = rsp_seen;
        repeat (4) step();
        check("drain_count", 64'(rsp_seen - seen0), 64'd2);

        // Only requesters 0 and 2 contend.
        bus.req_valid = 4'b0101;
        prev = -1;
        repeat (4) begin
            step();
            check("fair_alt", 64'((last_grant == 0 || last_grant == 2) && last_grant != prev), 64'd1);
            prev = last_grant;
        end
        bus.req_valid = '0;
        repeat (3) step();

        // Reset with two operations in flight.
        bus.req_valid = '1;
        repeat (2) step();
        reset_n = 1'b0;
        #1;
        check("midrst_rv", 64'(bus.rsp_valid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_ready", 64'(bus.req_ready), 64'd0);
        mreset();
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        bus.req_valid = '0;
        seen0 = rsp_seen;
        repeat (3) step();
        check("post_rst_quiet", 64'(rsp_seen - seen0), 64'd0);
        bus.req_valid = '1;
        step();
        check("post_rst_grant", 64'(last_grant), 64'd0);
        bus.req_valid = '0;
        repeat (3) step();

        // Random traffic with random backpressure.
        for (int k = 0; k < 300; k++) begin
            bus.req_valid = N'($urandom);
            bus.req_a = {$urandom, $urandom, $urandom, $urandom};
            bus.req_b = 60'({$urandom, $urandom});
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        repeat (4) step();
        check("final_idle", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
